// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master / one-slave Wishbone arbiter.
// Master 0 is the core's instruction port and master 1 is its data port.
// The bus is granted per Wishbone cycle (cyc) with round-robin tie
// breaking. A granted cycle is never preempted. A per-transfer watchdog
// raises a one-cycle err pulse to the owner when the slave stalls.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,

    // master 0 (instruction port)
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_sel,
    input  logic            m0_we,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    output logic            m0_err,

    // master 1 (data port)
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_sel,
    input  logic            m1_we,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            m1_err,

    // shared slave
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_sel,
    output logic            s_we,
    output logic            s_cyc,
    output logic            s_stb,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack
);

    // A zero TIMEOUT would give a zero-width counter; keep one bit and
    // disable the watchdog instead.
    localparam bit          WD_EN  = (TIMEOUT > 0);
    localparam int          CW     = WD_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t          state_reg;
    logic            last_reg;      // most recently granted master
    logic [CW-1:0]   count_reg;     // cycles of unacknowledged stb
    logic            err0_reg;
    logic            err1_reg;

    logic            leave;         // grant state changes at the next edge

    // Detect whether the grant state will change at the next edge; the
    // watchdog must restart whenever ownership moves.
    always_comb begin
        leave = 1'b0;
        case (state_reg)
            IDLE:    leave = m0_cyc | m1_cyc;
            G0:      leave = ~m0_cyc;
            G1:      leave = ~m1_cyc;
            default: leave = 1'b1;
        endcase
    end

    // Route the owner's request to the slave; an idle bus drives all zeros.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        case (state_reg)
            G0: begin
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_sel   = m0_sel;
                s_we    = m0_we;
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
            end
            G1: begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
            end
            default: ;
        endcase
    end

    // Read data goes to both masters; only the owner ever sees ack.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_ack   = s_ack & (state_reg == G0);
    assign m1_ack   = s_ack & (state_reg == G1);
    assign m0_err   = err0_reg;
    assign m1_err   = err1_reg;

    // Grant FSM, round-robin history and stall watchdog.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;          // master 0 wins the first tie
            count_reg <= '0;
            err0_reg  <= 1'b0;
            err1_reg  <= 1'b0;
        end else begin
            err0_reg <= 1'b0;
            err1_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (m0_cyc && (!m1_cyc || last_reg)) begin
                        state_reg <= G0;
                        last_reg  <= 1'b0;
                    end else if (m1_cyc) begin
                        state_reg <= G1;
                        last_reg  <= 1'b1;
                    end
                end
                G0: begin
                    // Hand straight over to a waiting master: no idle bubble.
                    if (!m0_cyc) begin
                        if (m1_cyc) begin
                            state_reg <= G1;
                            last_reg  <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                G1: begin
                    if (!m1_cyc) begin
                        if (m0_cyc) begin
                            state_reg <= G0;
                            last_reg  <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // The count only runs while the owner waits on an unacked strobe.
            // On expiry the grant is kept; the master decides to drop cyc.
            if (!WD_EN || leave || !(s_cyc && s_stb) || s_ack) begin
                count_reg <= '0;
            end else if (count_reg == TLIMIT) begin
                count_reg <= '0;
                err0_reg  <= (state_reg == G0);
                err1_reg  <= (state_reg == G1);
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule
